// File: rtl/axi_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_mem_arbiter_if
// One complete AXI4 port (AW, W, B, AR, R channels) shared by the arbiter's
// two upstream masters and its downstream memory port.
//
// Parameters: ID_W (ID width), ADDR_W (address width), DATA_W (data width,
// strobe width is DATA_W/8).
//
// Modports:
//   master - the side that issues requests (drives AW/W/AR and B/R ready)
//   slave  - the side that answers requests (drives AW/W/AR ready and B/R)
// ---------------------------------------------------------------------------
interface axi_mem_arbiter_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ID_W-1:0]       aw_id;
  logic [ADDR_W-1:0]     aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;

  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_W-1:0]     w_data;
  logic [DATA_W/8-1:0]   w_strb;
  logic                  w_last;

  logic                  b_valid;
  logic                  b_ready;
  logic [ID_W-1:0]       b_id;
  logic [1:0]            b_resp;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [ID_W-1:0]       ar_id;
  logic [ADDR_W-1:0]     ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;

  logic                  r_valid;
  logic                  r_ready;
  logic [ID_W-1:0]       r_id;
  logic [DATA_W-1:0]     r_data;
  logic [1:0]            r_resp;
  logic                  r_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );
endinterface

// File: rtl/axi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axi_mem_arbiter
// Two-master to one-slave AXI4 arbiter in front of the DDR memory path.
// Read and write paths are arbitrated independently, round-robin, with one
// burst outstanding per path. No grant is issued before DDR calibration.
//
// Ports:
//   clock      - sole clock
//   resetn     - synchronous, active-low reset
//   calib_done - DDR init_calib_complete level, gates new grants only
//   s0, s1     - upstream AXI4 ports (slave modport), master 0 and master 1
//   m          - downstream AXI4 port to the memory path (master modport)
// ---------------------------------------------------------------------------
module axi_mem_arbiter #(
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter logic [ADDR_W-1:0] ADDR_MASK = 32'h7fff_ffff
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                calib_done,
  axi_mem_arbiter_if.slave    s0,
  axi_mem_arbiter_if.slave    s1,
  axi_mem_arbiter_if.master   m
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wState_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rState_e;

  wState_e wState_q, wState_d;
  rState_e rState_q, rState_d;
  // Owner is the master holding the path; last is the master granted most
  // recently and is what the round-robin tie-break turns away from.
  logic    wOwner_q, wOwner_d, wLast_q, wLast_d;
  logic    rOwner_q, rOwner_d, rLast_q, rLast_d;

  // Last-granted resets to master 1 so that master 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wState_q <= W_IDLE;
      rState_q <= R_IDLE;
      wOwner_q <= 1'b0;
      rOwner_q <= 1'b0;
      wLast_q  <= 1'b1;
      rLast_q  <= 1'b1;
    end else begin
      wState_q <= wState_d;
      rState_q <= rState_d;
      wOwner_q <= wOwner_d;
      rOwner_q <= rOwner_d;
      wLast_q  <= wLast_d;
      rLast_q  <= rLast_d;
    end
  end

  // Write path next state. A lone requester wins outright; on a tie the
  // master not granted last time wins.
  always_comb begin
    wState_d = wState_q;
    wOwner_d = wOwner_q;
    wLast_d  = wLast_q;
    case (wState_q)
      W_IDLE: begin
        if (calib_done && (s0.aw_valid || s1.aw_valid)) begin
          wOwner_d = (s0.aw_valid && s1.aw_valid) ? ~wLast_q : s1.aw_valid;
          wLast_d  = wOwner_d;
          wState_d = W_ADDR;
        end
      end
      W_ADDR:  if (m.aw_valid && m.aw_ready) wState_d = W_DATA;
      W_DATA:  if (m.w_valid && m.w_ready && m.w_last) wState_d = W_RESP;
      W_RESP:  if (m.b_valid && m.b_ready) wState_d = W_IDLE;
      default: wState_d = W_IDLE;
    endcase
  end

  // Read path next state, same arbitration with its own pointer.
  always_comb begin
    rState_d = rState_q;
    rOwner_d = rOwner_q;
    rLast_d  = rLast_q;
    case (rState_q)
      R_IDLE: begin
        if (calib_done && (s0.ar_valid || s1.ar_valid)) begin
          rOwner_d = (s0.ar_valid && s1.ar_valid) ? ~rLast_q : s1.ar_valid;
          rLast_d  = rOwner_d;
          rState_d = R_ADDR;
        end
      end
      R_ADDR:  if (m.ar_valid && m.ar_ready) rState_d = R_DATA;
      R_DATA:  if (m.r_valid && m.r_ready && m.r_last) rState_d = R_IDLE;
      default: rState_d = R_IDLE;
    endcase
  end

  // Write channel routing. Everything idles at zero; each state opens exactly
  // one channel between the owner and the memory port. W is closed until the
  // address has been accepted, and a stray B outside W_RESP is never acked.
  always_comb begin
    m.aw_valid  = 1'b0;
    m.aw_id     = {ID_W{1'b0}};
    m.aw_addr   = {ADDR_W{1'b0}};
    m.aw_len    = 8'd0;
    m.aw_size   = 3'd0;
    m.aw_burst  = 2'd0;
    m.w_valid   = 1'b0;
    m.w_data    = {DATA_W{1'b0}};
    m.w_strb    = {(DATA_W/8){1'b0}};
    m.w_last    = 1'b0;
    m.b_ready   = 1'b0;
    s0.aw_ready = 1'b0;
    s1.aw_ready = 1'b0;
    s0.w_ready  = 1'b0;
    s1.w_ready  = 1'b0;
    s0.b_valid  = 1'b0;
    s0.b_id     = {ID_W{1'b0}};
    s0.b_resp   = 2'd0;
    s1.b_valid  = 1'b0;
    s1.b_id     = {ID_W{1'b0}};
    s1.b_resp   = 2'd0;
    case (wState_q)
      W_ADDR: begin
        if (!wOwner_q) begin
          m.aw_valid  = s0.aw_valid;
          m.aw_id     = s0.aw_id;
          m.aw_addr   = s0.aw_addr & ADDR_MASK;
          m.aw_len    = s0.aw_len;
          m.aw_size   = s0.aw_size;
          m.aw_burst  = s0.aw_burst;
          s0.aw_ready = m.aw_ready;
        end else begin
          m.aw_valid  = s1.aw_valid;
          m.aw_id     = s1.aw_id;
          m.aw_addr   = s1.aw_addr & ADDR_MASK;
          m.aw_len    = s1.aw_len;
          m.aw_size   = s1.aw_size;
          m.aw_burst  = s1.aw_burst;
          s1.aw_ready = m.aw_ready;
        end
      end
      W_DATA: begin
        if (!wOwner_q) begin
          m.w_valid  = s0.w_valid;
          m.w_data   = s0.w_data;
          m.w_strb   = s0.w_strb;
          m.w_last   = s0.w_last;
          s0.w_ready = m.w_ready;
        end else begin
          m.w_valid  = s1.w_valid;
          m.w_data   = s1.w_data;
          m.w_strb   = s1.w_strb;
          m.w_last   = s1.w_last;
          s1.w_ready = m.w_ready;
        end
      end
      W_RESP: begin
        if (!wOwner_q) begin
          s0.b_valid = m.b_valid;
          s0.b_id    = m.b_id;
          s0.b_resp  = m.b_resp;
          m.b_ready  = s0.b_ready;
        end else begin
          s1.b_valid = m.b_valid;
          s1.b_id    = m.b_id;
          s1.b_resp  = m.b_resp;
          m.b_ready  = s1.b_ready;
        end
      end
      default: ;
    endcase
  end

  // Read channel routing, same scheme as the write side.
  always_comb begin
    m.ar_valid  = 1'b0;
    m.ar_id     = {ID_W{1'b0}};
    m.ar_addr   = {ADDR_W{1'b0}};
    m.ar_len    = 8'd0;
    m.ar_size   = 3'd0;
    m.ar_burst  = 2'd0;
    m.r_ready   = 1'b0;
    s0.ar_ready = 1'b0;
    s1.ar_ready = 1'b0;
    s0.r_valid  = 1'b0;
    s0.r_id     = {ID_W{1'b0}};
    s0.r_data   = {DATA_W{1'b0}};
    s0.r_resp   = 2'd0;
    s0.r_last   = 1'b0;
    s1.r_valid  = 1'b0;
    s1.r_id     = {ID_W{1'b0}};
    s1.r_data   = {DATA_W{1'b0}};
    s1.r_resp   = 2'd0;
    s1.r_last   = 1'b0;
    case (rState_q)
      R_ADDR: begin
        if (!rOwner_q) begin
          m.ar_valid  = s0.ar_valid;
          m.ar_id     = s0.ar_id;
          m.ar_addr   = s0.ar_addr & ADDR_MASK;
          m.ar_len    = s0.ar_len;
          m.ar_size   = s0.ar_size;
          m.ar_burst  = s0.ar_burst;
          s0.ar_ready = m.ar_ready;
        end else begin
          m.ar_valid  = s1.ar_valid;
          m.ar_id     = s1.ar_id;
          m.ar_addr   = s1.ar_addr & ADDR_MASK;
          m.ar_len    = s1.ar_len;
          m.ar_size   = s1.ar_size;
          m.ar_burst  = s1.ar_burst;
          s1.ar_ready = m.ar_ready;
        end
      end
      R_DATA: begin
        if (!rOwner_q) begin
          s0.r_valid = m.r_valid;
          s0.r_id    = m.r_id;
          s0.r_data  = m.r_data;
          s0.r_resp  = m.r_resp;
          s0.r_last  = m.r_last;
          m.r_ready  = s0.r_ready;
        end else begin
          s1.r_valid = m.r_valid;
          s1.r_id    = m.r_id;
          s1.r_data  = m.r_data;
          s1.r_resp  = m.r_resp;
          s1.r_last  = m.r_last;
          m.r_ready  = s1.r_ready;
        end
      end
      default: ;
    endcase
  end

endmodule
